// File: rtl/rmw_counter_mem_pkg.sv
// Shared types for the read-modify-write counter memory: request opcodes and init FSM states.
package rmw_mem_pkg;

   typedef enum logic [1:0] {
      OP_INC  = 2'd0,
      OP_ADD  = 2'd1,
      OP_COPY = 2'd2,
      OP_READ = 2'd3
   } op_e;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/rmw_counter_mem_if.sv
// Request/response port of the counter memory; the requester uses master, the memory uses slave.
interface rmw_counter_mem_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
);
   import rmw_mem_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic             req_valid;
   logic             req_ready;
   op_e              req_op;
   logic [AW-1:0]    req_addr;
   logic [WIDTH-1:0] req_data;
   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_ovf;
   logic             init_done;

   modport master (
      output req_valid, req_op, req_addr, req_data,
      input  req_ready, rsp_valid, rsp_data, rsp_ovf, init_done
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_data,
      output req_ready, rsp_valid, rsp_data, rsp_ovf, init_done
   );

endinterface

// File: rtl/rmw_counter_mem_alu.sv
// Combinational op evaluation for the write stage: new value, carry-out flag and write enable.
module rmw_alu
   import rmw_mem_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int SATURATE = 0
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] old,
   input  logic [WIDTH-1:0] src,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] new_val,
   output logic             ovf,
   output logic             wr_en
);

   logic [WIDTH:0] sum_s;

   // INC is treated as ADD of one so both share the carry and clamp path
   always_comb begin
      sum_s   = '0;
      new_val = old;
      ovf     = 1'b0;
      wr_en   = 1'b0;
      case (op)
         OP_INC, OP_ADD: begin
            if (op == OP_INC) begin
               sum_s = {1'b0, old} + {{WIDTH{1'b0}}, 1'b1};
            end else begin
               sum_s = {1'b0, old} + {1'b0, data};
            end
            ovf   = sum_s[WIDTH];
            wr_en = 1'b1;
            if (sum_s[WIDTH] && (SATURATE != 0)) begin
               new_val = {WIDTH{1'b1}};
            end else begin
               new_val = sum_s[WIDTH-1:0];
            end
         end
         OP_COPY: begin
            new_val = src;
            wr_en   = 1'b1;
         end
         OP_READ: begin
            new_val = old;
            wr_en   = 1'b0;
         end
         default: begin
            new_val = old;
            wr_en   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/rmw_counter_mem.sv
// DEPTH x WIDTH counter table with a two-stage read/forward then compute/write pipeline,
// cleared by an init sweep after every reset.
module rmw_counter_mem
   import rmw_mem_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 8,
   parameter int COPY_OFFSET = 4,
   parameter int SATURATE    = 0
) (
   input logic               clk,
   input logic               reset,
   rmw_counter_mem_if.slave  bus
);

   localparam int            AW     = $clog2(DEPTH);
   localparam logic [AW-1:0] OFFSET = AW'(COPY_OFFSET);
   localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_r [DEPTH];

   state_e           state_r;
   state_e           state_s;
   logic [AW-1:0]    ptr_r;
   logic             init_done_r;

   logic             accept_s;
   logic [AW-1:0]    src_addr_s;
   logic [WIDTH-1:0] old_s;
   logic [WIDTH-1:0] src_s;

   logic             s2_valid_r;
   op_e              s2_op_r;
   logic [AW-1:0]    s2_addr_r;
   logic [WIDTH-1:0] s2_data_r;
   logic [WIDTH-1:0] s2_old_r;
   logic [WIDTH-1:0] s2_src_r;

   logic [WIDTH-1:0] alu_new_s;
   logic             alu_ovf_s;
   logic             alu_wr_s;
   logic             s2_wr_s;

   // DEPTH is a power of two, so dropping the carry gives the modulo
   assign accept_s   = bus.req_valid && init_done_r;
   assign src_addr_s = bus.req_addr + OFFSET;
   assign s2_wr_s    = s2_valid_r && alu_wr_s;

   rmw_alu #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
   ) u_alu (
      .op      (s2_op_r),
      .old     (s2_old_r),
      .src     (s2_src_r),
      .data    (s2_data_r),
      .new_val (alu_new_s),
      .ovf     (alu_ovf_s),
      .wr_en   (alu_wr_s)
   );

   // Init sweep ends after the last entry is cleared
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_INIT: begin
            if (ptr_r == LAST) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_INIT;
            end
         end
         ST_RUN:  state_s = ST_RUN;
         default: state_s = ST_INIT;
      endcase
   end

   // FSM state, sweep pointer and ready flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_INIT;
         ptr_r       <= '0;
         init_done_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         init_done_r <= (state_s == ST_RUN);
         if (state_r == ST_INIT) begin
            ptr_r <= ptr_r + AW'(1);
         end
      end
   end

   // Bypass the stage-2 write so back-to-back ops see serial results
   always_comb begin
      if (s2_wr_s && (s2_addr_r == bus.req_addr)) begin
         old_s = alu_new_s;
      end else begin
         old_s = mem_r[bus.req_addr];
      end
      if (s2_wr_s && (s2_addr_r == src_addr_s)) begin
         src_s = alu_new_s;
      end else begin
         src_s = mem_r[src_addr_s];
      end
   end

   // Stage-2 operand registers
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid_r <= 1'b0;
         s2_op_r    <= OP_READ;
         s2_addr_r  <= '0;
         s2_data_r  <= '0;
         s2_old_r   <= '0;
         s2_src_r   <= '0;
      end else begin
         s2_valid_r <= accept_s;
         if (accept_s) begin
            s2_op_r   <= bus.req_op;
            s2_addr_r <= bus.req_addr;
            s2_data_r <= bus.req_data;
            s2_old_r  <= old_s;
            s2_src_r  <= src_s;
         end
      end
   end

   // Array writes; reset suppresses any in-flight stage-2 write
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_r == ST_INIT) begin
            mem_r[ptr_r] <= '0;
         end else if (s2_wr_s) begin
            mem_r[s2_addr_r] <= alu_new_s;
         end
      end
   end

   assign bus.req_ready = init_done_r;
   assign bus.init_done = init_done_r;
   assign bus.rsp_valid = s2_valid_r;
   assign bus.rsp_data  = s2_old_r;
   assign bus.rsp_ovf   = s2_valid_r && alu_ovf_s;

endmodule

// File: tb/tb_rmw_counter_mem.sv
// Bench for rmw_counter_mem: a wrapping and a saturating instance share one request stream,
// responses are checked against per-instance scoreboards.
module tb_rmw_counter_mem;
   import rmw_mem_pkg::*;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int OFF   = 4;
   localparam int AW    = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   rmw_counter_mem_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
   rmw_counter_mem_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

   rmw_counter_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COPY_OFFSET(OFF), .SATURATE(0)) dut_wrap (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   rmw_counter_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COPY_OFFSET(OFF), .SATURATE(1)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   assign bus1.req_valid = bus0.req_valid;
   assign bus1.req_op    = bus0.req_op;
   assign bus1.req_addr  = bus0.req_addr;
   assign bus1.req_data  = bus0.req_data;

   typedef struct {
      int               due;
      logic [WIDTH-1:0] data;
      logic             ovf;
   } exp_t;

   typedef struct {
      op_e              op;
      int               addr;
      logic [WIDTH-1:0] data;
      logic [WIDTH-1:0] exp_data;
      logic             exp_ovf;
   } vec_t;

   exp_t             q0[$];
   exp_t             q1[$];
   logic [WIDTH-1:0] m0 [DEPTH];
   logic [WIDTH-1:0] m1 [DEPTH];
   int               errors    = 0;
   int               checks    = 0;
   int               cyc       = 0;
   bit               chk_en    = 1'b0;
   bit               ready_exp = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void model(input op_e op, input logic [WIDTH-1:0] old, input logic [WIDTH-1:0] src,
                                 input logic [WIDTH-1:0] data, input bit sat,
                                 output logic [WIDTH-1:0] nv, output logic ovf, output bit wr);
      logic [63:0] t;
      t   = 64'd0;
      nv  = old;
      ovf = 1'b0;
      wr  = 1'b0;
      case (op)
         OP_INC, OP_ADD: begin
            t   = {32'd0, old} + ((op == OP_INC) ? 64'd1 : {32'd0, data});
            ovf = (t > 64'h0000_0000_FFFF_FFFF);
            wr  = 1'b1;
            nv  = (ovf && sat) ? 32'hFFFF_FFFF : t[31:0];
         end
         OP_COPY: begin
            nv = src;
            wr = 1'b1;
         end
         default: wr = 1'b0;
      endcase
   endfunction

   task automatic cmp_rsp(input string nm, input bit exp_v, input exp_t e,
                          input logic v, input logic [WIDTH-1:0] d, input logic o);
      checks++;
      if (v !== exp_v) begin
         errors++;
         $display("FAIL %s rsp_valid: got %0b want %0b (cycle %0d)", nm, v, exp_v, cyc);
      end else if (exp_v) begin
         checks++;
         if (d !== e.data || o !== e.ovf) begin
            errors++;
            $display("FAIL %s rsp: got data=%h ovf=%0b want data=%h ovf=%0b (cycle %0d)",
                     nm, d, o, e.data, e.ovf, cyc);
         end
      end
   endtask

   // Scoreboard: a response is due exactly one cycle after acceptance
   always @(negedge clk) begin
      bit   v0, v1;
      exp_t e0, e1;
      if (chk_en) begin
         v0 = (q0.size() > 0) && (q0[0].due == cyc);
         v1 = (q1.size() > 0) && (q1[0].due == cyc);
         e0 = '{0, '0, 1'b0};
         e1 = '{0, '0, 1'b0};
         if (v0) e0 = q0.pop_front();
         if (v1) e1 = q1.pop_front();
         cmp_rsp("wrap", v0, e0, bus0.rsp_valid, bus0.rsp_data, bus0.rsp_ovf);
         cmp_rsp("sat", v1, e1, bus1.rsp_valid, bus1.rsp_data, bus1.rsp_ovf);
      end
   end

   task automatic issue(input bit valid, input op_e op, input int addr, input logic [WIDTH-1:0] data,
                        input bit use_tab, input logic [WIDTH-1:0] tab_data, input bit tab_ovf);
      logic [WIDTH-1:0] nv;
      logic             ov;
      bit               wr;
      int               src;
      exp_t             e;
      @(posedge clk);
      #1;
      bus0.req_valid = valid;
      bus0.req_op    = op;
      bus0.req_addr  = addr[AW-1:0];
      bus0.req_data  = data;
      if (valid && ready_exp) begin
         src = (addr + OFF) % DEPTH;
         model(op, m0[addr], m0[src], data, 1'b0, nv, ov, wr);
         e.due  = cyc + 1;
         e.data = use_tab ? tab_data : m0[addr];
         e.ovf  = use_tab ? tab_ovf : ov;
         q0.push_back(e);
         if (wr) m0[addr] = nv;
         model(op, m1[addr], m1[src], data, 1'b1, nv, ov, wr);
         e.data = m1[addr];
         e.ovf  = ov;
         q1.push_back(e);
         if (wr) m1[addr] = nv;
      end
   endtask

   task automatic idle();
      issue(1'b0, OP_READ, 0, '0, 1'b0, '0, 1'b0);
   endtask

   // Hold reset n cycles, then verify the init sweep length; requests during init must be ignored
   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      reset          = 1'b1;
      bus0.req_valid = 1'b0;
      ready_exp      = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         m0[i] = '0;
         m1[i] = '0;
      end
      chk_en = 1'b1;
      for (int k = 0; k <= DEPTH; k++) begin
         bus0.req_valid = (k < 3);
         bus0.req_op    = OP_INC;
         bus0.req_addr  = 3'd2;
         bus0.req_data  = 32'd0;
         @(negedge clk);
         checks++;
         if (bus0.init_done !== (k == DEPTH) || bus0.req_ready !== (k == DEPTH)) begin
            errors++;
            $display("FAIL init_timing k=%0d: got init_done=%0b req_ready=%0b want %0b",
                     k, bus0.init_done, bus0.req_ready, (k == DEPTH));
         end
         checks++;
         if (bus1.init_done !== (k == DEPTH)) begin
            errors++;
            $display("FAIL init_timing_sat k=%0d: got %0b want %0b", k, bus1.init_done, (k == DEPTH));
         end
         if (k < DEPTH) begin
            @(posedge clk);
            #1;
         end
      end
      ready_exp = 1'b1;
   endtask

   vec_t tab[$];

   initial begin
      tab.push_back('{OP_INC,  3, 32'h0,          32'h0,          1'b0});
      tab.push_back('{OP_INC,  3, 32'h0,          32'h1,          1'b0});
      tab.push_back('{OP_INC,  3, 32'h0,          32'h2,          1'b0});
      tab.push_back('{OP_READ, 3, 32'h0,          32'h3,          1'b0});
      tab.push_back('{OP_ADD,  1, 32'hFFFF_FFFE,  32'h0,          1'b0});
      tab.push_back('{OP_ADD,  1, 32'h3,          32'hFFFF_FFFE,  1'b1});
      tab.push_back('{OP_READ, 1, 32'h0,          32'h1,          1'b0});
      tab.push_back('{OP_COPY, 1, 32'h0,          32'h1,          1'b0});
      tab.push_back('{OP_ADD,  1, 32'h55,         32'h0,          1'b0});
      tab.push_back('{OP_COPY, 5, 32'h0,          32'h0,          1'b0});
      tab.push_back('{OP_COPY, 1, 32'h0,          32'h55,         1'b0});
      tab.push_back('{OP_READ, 5, 32'h0,          32'h55,         1'b0});
      tab.push_back('{OP_READ, 1, 32'h0,          32'h55,         1'b0});
      tab.push_back('{OP_ADD,  6, 32'h9,          32'h0,          1'b0});
      tab.push_back('{OP_INC,  6, 32'h0,          32'h9,          1'b0});
      tab.push_back('{OP_COPY, 2, 32'h0,          32'h0,          1'b0});
      tab.push_back('{OP_READ, 2, 32'h0,          32'hA,          1'b0});
      tab.push_back('{OP_ADD,  7, 32'hFFFF_FFFF,  32'h0,          1'b0});
      tab.push_back('{OP_INC,  7, 32'h0,          32'hFFFF_FFFF,  1'b1});
      tab.push_back('{OP_READ, 7, 32'h0,          32'h0,          1'b0});
      tab.push_back('{OP_READ, 4, 32'h0,          32'h0,          1'b0});
      tab.push_back('{OP_READ, 6, 32'h0,          32'hA,          1'b0});

      bus0.req_valid = 1'b0;
      bus0.req_op    = OP_READ;
      bus0.req_addr  = 3'd0;
      bus0.req_data  = 32'd0;

      do_reset(3);
      for (int a = 0; a < DEPTH; a++) issue(1'b1, OP_READ, a, '0, 1'b1, 32'h0, 1'b0);

      for (int i = 0; i < tab.size(); i++)
         issue(1'b1, tab[i].op, tab[i].addr, tab[i].data, 1'b1, tab[i].exp_data, tab[i].exp_ovf);
      idle();

      for (int i = 0; i < 80; i++) begin
         logic [WIDTH-1:0] d;
         d = ($urandom_range(0, 1) == 0) ? $urandom() : 32'hFFFF_FFF0 + $urandom_range(0, 15);
         issue($urandom_range(0, 3) != 0, op_e'($urandom_range(0, 3)), $urandom_range(0, DEPTH - 1),
               d, 1'b0, '0, 1'b0);
      end
      idle();

      // Reset arrives the cycle after an accepted INC
      issue(1'b1, OP_INC, 0, '0, 1'b0, '0, 1'b0);
      do_reset(3);
      issue(1'b1, OP_READ, 0, '0, 1'b1, 32'h0, 1'b0);
      for (int a = 0; a < DEPTH; a++) issue(1'b1, OP_READ, a, '0, 1'b0, '0, 1'b0);
      repeat (3) idle();

      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL pending_rsp: got %0d/%0d outstanding want 0", q0.size(), q1.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
